// File: rtl/demosaic_pkg.sv
// rtl/demosaic_pkg.sv - shared types and constants for the demosaic frame controller
// Holds the controller state encoding, default memory geometry, channel
// lane indices and the frame-size helper used when validating a request.
package demosaic_pkg;

  localparam int IMG_SIZE = 16384;  // pixel capacity of each channel memory
  localparam int ADDR_W   = 16;     // channel-memory address width
  localparam int TOTAL_W  = 17;     // 8-bit rows * 9-bit cols never exceeds 17 bits

  // Lane position of each colour inside the packed {b,g,r} buses
  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    READ
  } ctrl_state_e;

  function automatic logic [TOTAL_W-1:0] frame_total(input logic [7:0] h,
                                                     input logic [8:0] w);
    return TOTAL_W'(h) * TOTAL_W'(w);
  endfunction

endpackage

// File: rtl/demosaic_pix_streamer.sv
// rtl/demosaic_pix_streamer.sv - read pointer and valid/ready pixel handshake
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   en         : controller is in READ; drives valid
//   clear      : rewind rd_ptr to 0 (core just finished)
//   total      : pixel count of the current frame
//   ready      : downstream accept
//   valid      : pixel rd_ptr is presented
//   last       : presented pixel is the final one of the frame
//   rd_ptr     : index of the presented pixel
//   done       : handshake on the last pixel this cycle
module demosaic_pix_streamer
  import demosaic_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               clear,
  input  logic [TOTAL_W-1:0] total,
  input  logic               ready,
  output logic               valid,
  output logic               last,
  output logic [TOTAL_W-1:0] rd_ptr,
  output logic               done
);

  assign valid = en;
  assign last  = en && (rd_ptr == total - TOTAL_W'(1));
  assign done  = valid && ready && last;

  // Pointer only moves on a handshake, so pixel data and last hold during stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
    end else if (valid && ready) begin
      rd_ptr <= rd_ptr + TOTAL_W'(1);
    end
  end

endmodule

// File: rtl/demosaic_frame_ctrl.sv
// rtl/demosaic_frame_ctrl.sv - frame sequencer and channel-memory owner for the demosaic core
// Ports:
//   clk, reset               : clock, asynchronous active-high reset
//   start_valid/start_ready  : frame request handshake (ready only in IDLE)
//   cfg_height/cfg_width     : requested frame size, sampled on the handshake
//   core_in_en               : one-cycle load pulse to the core
//   core_height/core_width   : latched frame size to the core
//   core_done                : core completion (honoured only in RUN)
//   core_wr/addr/wdata/rdata : core side of the {b,g,r} channel memories
//   mem_wr/addr/wdata/rdata  : channel memories (read data combinational)
//   pix_valid/ready/rgb/last : RGB pixel output stream
//   busy                     : controller not idle
//   err_cfg                  : one-cycle pulse, request rejected
//   err_timeout              : sticky, core did not finish in time
//   err_stray                : sticky, core write attempted outside RUN
module demosaic_frame_ctrl #(
  parameter int IMG_SIZE = 16384,
  parameter int ADDR_W   = 16,
  parameter int TIMEOUT  = 2**20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [7:0]        cfg_height,
  input  logic [8:0]        cfg_width,
  output logic              core_in_en,
  output logic [7:0]        core_height,
  output logic [8:0]        core_width,
  input  logic              core_done,
  input  logic [2:0]        core_wr,
  input  logic [3*ADDR_W-1:0] core_addr,
  input  logic [23:0]       core_wdata,
  output logic [23:0]       core_rdata,
  output logic [2:0]        mem_wr,
  output logic [3*ADDR_W-1:0] mem_addr,
  output logic [23:0]       mem_wdata,
  input  logic [23:0]       mem_rdata,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [23:0]       pix_rgb,
  output logic              pix_last,
  output logic              busy,
  output logic              err_cfg,
  output logic              err_timeout,
  output logic              err_stray
);

  import demosaic_pkg::ctrl_state_e;
  import demosaic_pkg::IDLE;
  import demosaic_pkg::LOAD;
  import demosaic_pkg::RUN;
  import demosaic_pkg::READ;
  import demosaic_pkg::TOTAL_W;
  import demosaic_pkg::CH_R;
  import demosaic_pkg::CH_G;
  import demosaic_pkg::CH_B;
  import demosaic_pkg::frame_total;

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  ctrl_state_e        state, state_nxt;
  logic [CNT_W-1:0]   run_cnt;
  logic [TOTAL_W-1:0] total;
  logic [TOTAL_W-1:0] req_total;
  logic [TOTAL_W-1:0] rd_ptr;
  logic               start_fire, cfg_bad, accept;
  logic               timeout_hit, stray, read_done;

  assign start_fire = start_valid && (state == IDLE);
  assign req_total  = frame_total(cfg_height, cfg_width);
  assign cfg_bad    = (cfg_height == '0) || (cfg_width == '0) ||
                      (req_total > TOTAL_W'(IMG_SIZE));
  assign accept     = start_fire && !cfg_bad;
  // core_done outranks the timeout when both land in the same cycle
  assign timeout_hit = (state == RUN) && !core_done &&
                       (run_cnt == CNT_W'(TIMEOUT - 1));
  assign stray       = (state != RUN) && (|core_wr);

  assign start_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign core_in_en  = (state == LOAD);
  assign core_rdata  = mem_rdata;

  demosaic_pix_streamer u_streamer (
    .clk    (clk),
    .reset  (reset),
    .en     (state == READ),
    .clear  ((state == RUN) && core_done),
    .total  (total),
    .ready  (pix_ready),
    .valid  (pix_valid),
    .last   (pix_last),
    .rd_ptr (rd_ptr),
    .done   (read_done)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = LOAD;
      LOAD: state_nxt = RUN;
      RUN: begin
        if (core_done)        state_nxt = READ;
        else if (timeout_hit) state_nxt = IDLE;
      end
      READ: if (read_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      run_cnt     <= '0;
      total       <= '0;
      core_height <= '0;
      core_width  <= '0;
      err_cfg     <= 1'b0;
      err_timeout <= 1'b0;
      err_stray   <= 1'b0;
    end else begin
      state   <= state_nxt;
      err_cfg <= start_fire && cfg_bad;
      // Counter measures cycles spent in the current RUN; zero elsewhere
      run_cnt <= (state == RUN) ? run_cnt + CNT_W'(1) : '0;
      if (accept) begin
        core_height <= cfg_height;
        core_width  <= cfg_width;
        total       <= req_total;
      end
      if (timeout_hit)  err_timeout <= 1'b1;
      else if (accept)  err_timeout <= 1'b0;
      // A stray write in the same cycle as an accepted start is still recorded
      if (stray)        err_stray <= 1'b1;
      else if (accept)  err_stray <= 1'b0;
    end
  end

  // Memory-port ownership: core in RUN, read pointer in READ, idle otherwise
  always_comb begin
    mem_wr    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    pix_rgb   = '0;
    if (state == RUN) begin
      mem_wr    = core_wr;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (state == READ) begin
      mem_addr[CH_R*ADDR_W +: ADDR_W] = rd_ptr[ADDR_W-1:0];
      mem_addr[CH_G*ADDR_W +: ADDR_W] = rd_ptr[ADDR_W-1:0];
      mem_addr[CH_B*ADDR_W +: ADDR_W] = rd_ptr[ADDR_W-1:0];
      pix_rgb = mem_rdata;
    end
  end

endmodule

// File: tb/tb_demosaic_frame_ctrl.sv
// tb/tb_demosaic_frame_ctrl.sv - scoreboard bench for demosaic_frame_ctrl
module tb_demosaic_frame_ctrl;

  localparam int ADDR_W   = 16;
  localparam int IMG_SIZE = 16384;
  localparam int TIMEOUT  = 64;
  localparam int MEM_AW   = 14;

  logic                clk, reset;
  logic                start_valid, start_ready;
  logic [7:0]          cfg_height, core_height;
  logic [8:0]          cfg_width, core_width;
  logic                core_in_en, core_done;
  logic [2:0]          core_wr, mem_wr;
  logic [3*ADDR_W-1:0] core_addr, mem_addr;
  logic [23:0]         core_wdata, core_rdata, mem_wdata, mem_rdata;
  logic                pix_valid, pix_ready, pix_last;
  logic [23:0]         pix_rgb;
  logic                busy, err_cfg, err_timeout, err_stray;

  demosaic_frame_ctrl #(.IMG_SIZE(IMG_SIZE), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .start_valid(start_valid), .start_ready(start_ready),
    .cfg_height(cfg_height), .cfg_width(cfg_width),
    .core_in_en(core_in_en), .core_height(core_height), .core_width(core_width),
    .core_done(core_done), .core_wr(core_wr), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_rgb(pix_rgb), .pix_last(pix_last),
    .busy(busy), .err_cfg(err_cfg), .err_timeout(err_timeout), .err_stray(err_stray)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Channel memories: synchronous write, combinational read
  logic [7:0] mem_r [0:IMG_SIZE-1];
  logic [7:0] mem_g [0:IMG_SIZE-1];
  logic [7:0] mem_b [0:IMG_SIZE-1];
  assign mem_rdata = {mem_b[mem_addr[2*ADDR_W +: MEM_AW]],
                      mem_g[mem_addr[1*ADDR_W +: MEM_AW]],
                      mem_r[mem_addr[0*ADDR_W +: MEM_AW]]};
  always @(posedge clk) begin
    if (mem_wr[0]) mem_r[mem_addr[0*ADDR_W +: MEM_AW]] <= mem_wdata[7:0];
    if (mem_wr[1]) mem_g[mem_addr[1*ADDR_W +: MEM_AW]] <= mem_wdata[15:8];
    if (mem_wr[2]) mem_b[mem_addr[2*ADDR_W +: MEM_AW]] <= mem_wdata[23:16];
  end

  int n_pass  = 0;
  int n_total = 0;
  logic [24:0] exp_q[$];   // {last, rgb}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: pops the scoreboard on every handshake, checks hold during stalls
  logic        prev_stall = 1'b0;
  logic [24:0] prev_pix;
  logic [24:0] mon_e;
  always @(negedge clk) begin
    if (!reset && pix_valid) begin
      if (prev_stall) chk("stall_stable", {7'd0, pix_last, pix_rgb}, {7'd0, prev_pix});
      if (pix_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pixel", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pix_rgb", {8'd0, pix_rgb}, {8'd0, mon_e[23:0]});
          chk("pix_last", {31'd0, pix_last}, {31'd0, mon_e[24]});
        end
      end
      prev_stall = !pix_ready;
      prev_pix   = {pix_last, pix_rgb};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input int h, input int w);
    start_valid = 1'b1;
    cfg_height  = 8'(h);
    cfg_width   = 9'(w);
    tick();
    start_valid = 1'b0;
  endtask

  task automatic reject_chk(input int h, input int w);
    start_req(h, w);
    chk("rej_err_cfg", {31'd0, err_cfg}, 32'd1);
    chk("rej_no_in_en", {31'd0, core_in_en}, 32'd0);
    chk("rej_start_ready", {31'd0, start_ready}, 32'd1);
    tick();
    chk("rej_err_cfg_pulse", {31'd0, err_cfg}, 32'd0);
    chk("rej_no_in_en2", {31'd0, core_in_en}, 32'd0);
  endtask

  // Issues a frame: the core model writes channel c = addr + base_c during the
  // first h*w RUN cycles and raises core_done in RUN cycle done_at.
  task automatic do_frame(input int h, input int w, input logic [7:0] rb,
                          input logic [7:0] gb, input logic [7:0] bb, input int done_at);
    int n;
    logic [7:0] a;
    n = h * w;
    for (int i = 0; i < n; i++) begin
      a = 8'(i);
      exp_q.push_back({(i == n - 1), a + bb, a + gb, a + rb});
    end
    start_req(h, w);
    chk("in_en_pulse", {31'd0, core_in_en}, 32'd1);
    chk("core_height", {24'd0, core_height}, 32'(h));
    chk("core_width", {23'd0, core_width}, 32'(w));
    chk("err_timeout_clr", {31'd0, err_timeout}, 32'd0);
    tick();
    chk("in_en_once", {31'd0, core_in_en}, 32'd0);
    for (int c = 1; c <= done_at; c++) begin
      if (c <= n) begin
        a          = 8'(c - 1);
        core_wr    = 3'b111;
        core_addr  = {3{ADDR_W'(c - 1)}};
        core_wdata = {a + bb, a + gb, a + rb};
      end else begin
        core_wr = 3'b000;
      end
      core_done = (c == done_at);
      if (core_done) chk("no_valid_before_done", {31'd0, pix_valid}, 32'd0);
      tick();
      core_wr   = 3'b000;
      core_done = 1'b0;
    end
    chk("valid_after_done", {31'd0, pix_valid}, 32'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && busy; k++) tick();
    chk("drain_idle", {31'd0, busy}, 32'd0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic reset_state_chk();
    chk("rst_start_ready", {31'd0, start_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
    chk("rst_pix_last", {31'd0, pix_last}, 32'd0);
    chk("rst_mem_wr", {29'd0, mem_wr}, 32'd0);
    chk("rst_core_in_en", {31'd0, core_in_en}, 32'd0);
    chk("rst_height", {24'd0, core_height}, 32'd0);
    chk("rst_width", {23'd0, core_width}, 32'd0);
  endtask

  int pat[4] = '{1, 0, 0, 1};

  initial begin
    reset = 1'b1; start_valid = 1'b0; cfg_height = '0; cfg_width = '0;
    core_done = 1'b0; core_wr = '0; core_addr = '0; core_wdata = '0; pix_ready = 1'b1;
    tick(); tick();
    reset_state_chk();
    chk("rst_err_timeout", {31'd0, err_timeout}, 32'd0);
    chk("rst_err_stray", {31'd0, err_stray}, 32'd0);
    reset = 1'b0;
    tick();

    // 4x4 frame, free-flowing output
    do_frame(4, 4, 8'h00, 8'h00, 8'h00, 40);
    for (int k = 0; k < 40 && !(pix_valid && pix_last); k++) tick();
    chk("t1_last_seen", {31'd0, pix_valid && pix_last}, 32'd1);
    chk("t1_busy_on_last", {31'd0, busy}, 32'd1);
    tick();
    chk("t1_busy_fell", {31'd0, busy}, 32'd0);
    chk("t1_valid_fell", {31'd0, pix_valid}, 32'd0);
    chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // Rejected requests, including one just over capacity
    reject_chk(0, 4);
    reject_chk(4, 0);
    reject_chk(255, 511);
    reject_chk(129, 128);

    // Stray write in IDLE
    core_wr = 3'b111;
    #1;
    chk("idle_mem_wr", {29'd0, mem_wr}, 32'd0);
    tick();
    core_wr = 3'b000;
    chk("idle_err_stray", {31'd0, err_stray}, 32'd1);

    // Timeout: core never finishes
    start_req(2, 2);
    tick();
    chk("t3_stray_cleared", {31'd0, err_stray}, 32'd0);
    for (int k = 0; k < TIMEOUT - 1; k++) tick();
    chk("t3_still_run", {31'd0, busy}, 32'd1);
    chk("t3_no_timeout_yet", {31'd0, err_timeout}, 32'd0);
    tick();
    chk("t3_idle", {31'd0, busy}, 32'd0);
    chk("t3_err_timeout", {31'd0, err_timeout}, 32'd1);
    tick(); tick();
    reject_chk(0, 1);
    chk("t3_timeout_sticky", {31'd0, err_timeout}, 32'd1);
    pix_ready = 1'b1;
    do_frame(2, 2, 8'h01, 8'h02, 8'h03, 10);
    drain();

    // 2x3 frame with 1-0-0-1 ready pattern
    do_frame(2, 3, 8'h10, 8'h20, 8'h30, 8);
    for (int k = 0; k < 40 && busy; k++) begin
      pix_ready = pat[k % 4][0];
      tick();
    end
    pix_ready = 1'b1;
    drain();

    // Stray write during READ while stalled
    pix_ready = 1'b0;
    do_frame(2, 2, 8'h21, 8'h22, 8'h23, 6);
    core_wr = 3'b111;
    #1;
    chk("read_mem_wr", {29'd0, mem_wr}, 32'd0);
    tick();
    core_wr = 3'b000;
    chk("read_err_stray", {31'd0, err_stray}, 32'd1);
    pix_ready = 1'b1;
    drain();

    // core_done in the same cycle the timeout would fire
    do_frame(2, 2, 8'h05, 8'h06, 8'h07, TIMEOUT);
    chk("t6_in_read", {31'd0, busy}, 32'd1);
    chk("t6_no_timeout", {31'd0, err_timeout}, 32'd0);
    drain();

    // Reset during RUN of a full-capacity frame
    start_req(128, 128);
    chk("t5_full_accept", {31'd0, core_in_en}, 32'd1);
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    reset_state_chk();
    tick();
    reset = 1'b0;
    tick();

    // Reset during READ after 3 pixels
    pix_ready = 1'b0;
    do_frame(2, 3, 8'h40, 8'h50, 8'h60, 8);
    pix_ready = 1'b1;
    tick(); tick(); tick();
    pix_ready = 1'b0;
    chk("t5_three_popped", 32'(exp_q.size()), 32'd3);
    reset = 1'b1;
    #1;
    reset_state_chk();
    exp_q.delete();
    tick();
    reset = 1'b0;
    tick();
    pix_ready = 1'b1;
    do_frame(2, 2, 8'h70, 8'h71, 8'h72, 6);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
